cpu_seq_ctrl: RTL

- Multi-cycle sequencer for the single-issue core: FETCH -> DECODE -> (MEM) -> WB, one instruction in flight.
- Drives IFU fetch request, LSU access request, and the inst_valid/lsu_done pair that the writeback unit ANDs into its PC update enable.
- Latches the fetched instruction, detects halt (ebreak), and traps hung fetch/memory transactions with a watchdog.
- Exports a retired-instruction counter.

---
 rtl/cpu_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl
//   Multi-cycle sequencer for the single-issue core. It walks one instruction
//   at a time through FETCH -> DECODE -> (MEM) -> WB. It latches the fetched
//   instruction and stops in HALT on ebreak. A watchdog moves it to ERR when
//   a fetch or memory transaction hangs. It also counts retired instructions.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   ifu_req        fetch request, high while in FETCH
//   ifu_rvalid     fetch data valid pulse
//   ifu_inst       fetched instruction, valid with ifu_rvalid
//   inst_reg       latched current instruction, feeds the decoder
//   dec_is_mem     decoder: inst_reg is a load/store
//   dec_halt       decoder: inst_reg is ebreak
//   lsu_req        memory access request, high while in MEM
//   lsu_done       LSU completion pulse
//   wb_inst_valid  writeback strobe, high only in WB
//   wb_lsu_done    writeback strobe, high only in WB
//   state_o        current state encoding (debug)
//   halted         high in HALT
//   err            high in ERR
//   retire_cnt     instructions retired since reset
module cpu_seq_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_rvalid,
  input  logic [31:0]      ifu_inst,
  output logic [31:0]      inst_reg,
  input  logic             dec_is_mem,
  input  logic             dec_halt,
  output logic             lsu_req,
  input  logic             lsu_done,
  output logic             wb_inst_valid,
  output logic             wb_lsu_done,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [WAIT_W-1:0]  r_wait;
  logic [31:0]        r_inst;
  logic [CNT_W-1:0]   r_retire;
  logic               r_ifu_req;
  logic               r_lsu_req;
  logic               r_wb;
  logic               r_halted;
  logic               r_err;
  logic               w_timeout;

  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  // Next state. A completing handshake is checked before the timeout, so
  // data arriving on the last allowed cycle is still accepted.
  always_comb begin
    w_nxt = S_ERR;
    case (r_state)
      S_FETCH: begin
        if (ifu_rvalid)     w_nxt = S_DECODE;
        else if (w_timeout) w_nxt = S_ERR;
        else                w_nxt = S_FETCH;
      end
      S_DECODE: begin
        if (dec_halt)        w_nxt = S_HALT;
        else if (dec_is_mem) w_nxt = S_MEM;
        else                 w_nxt = S_WB;
      end
      S_MEM: begin
        if (lsu_done)       w_nxt = S_WB;
        else if (w_timeout) w_nxt = S_ERR;
        else                w_nxt = S_MEM;
      end
      S_WB:    w_nxt = S_FETCH;
      S_HALT:  w_nxt = S_HALT;
      S_ERR:   w_nxt = S_ERR;
      default: w_nxt = S_ERR;
    endcase
  end

  // The output flops are loaded from the next state. Each output then
  // matches the state register exactly, and it comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_inst    <= '0;
      r_retire  <= '0;
      r_ifu_req <= 1'b1;
      r_lsu_req <= 1'b0;
      r_wb      <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // The watchdog restarts on every state entry. It only advances while
      // the sequencer waits in FETCH or MEM.
      if (w_nxt != r_state)
        r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_wait <= r_wait + WAIT_W'(1);
      if (r_state == S_FETCH && ifu_rvalid)
        r_inst <= ifu_inst;
      if (r_state == S_WB)
        r_retire <= r_retire + CNT_W'(1);
      r_ifu_req <= (w_nxt == S_FETCH);
      r_lsu_req <= (w_nxt == S_MEM);
      r_wb      <= (w_nxt == S_WB);
      r_halted  <= (w_nxt == S_HALT);
      r_err     <= (w_nxt == S_ERR);
    end
  end

  assign ifu_req       = r_ifu_req;
  assign lsu_req       = r_lsu_req;
  assign wb_inst_valid = r_wb;
  assign wb_lsu_done   = r_wb;
  assign halted        = r_halted;
  assign err           = r_err;
  assign inst_reg      = r_inst;
  assign retire_cnt    = r_retire;
  assign state_o       = r_state;

endmodule
